rr_req_frontend: RTL

//  Requester-side front end of the round-robin arbitration interface.

---
 rtl/rr_req_frontend.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_req_frontend.sv
// Requester-side front end for a round-robin arbiter. Per-port FIFOs raise requests.
// A legal one-hot grant moves that port's head word into a registered valid/ready output.
module rr_req_frontend #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         in_valid,
    output logic [NUM_PORTS-1:0]         in_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]  in_data,
    output logic [NUM_PORTS-1:0]         req_o,
    input  logic [NUM_PORTS-1:0]         gnt_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    output logic                         err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NUM_PORTS);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0]    mem    [NUM_PORTS][DEPTH];
    logic [PW-1:0]        wr_ptr [NUM_PORTS];
    logic [PW-1:0]        rd_ptr [NUM_PORTS];
    logic [CW-1:0]        count  [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] take;
    logic                 can_load;
    logic                 gnt_multi;
    logic                 gnt_stray;
    logic                 take_onehot;
    logic                 load;
    logic [IW-1:0]        take_idx;

    // in_ready looks only at the registered count, so a pop never frees a slot in the same cycle.
    always_comb begin
        empty    = '0;
        in_ready = '0;
        push     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            empty[p]    = (count[p] == '0);
            in_ready[p] = (count[p] != FULL_CNT);
            push[p]     = in_valid[p] && in_ready[p];
        end
    end

    // Requests are withheld while the output register cannot take a new word.
    assign can_load    = !out_valid || out_ready;
    assign req_o       = ~empty & {NUM_PORTS{can_load}};
    assign take        = gnt_i & req_o;
    assign gnt_multi   = (gnt_i & (gnt_i - NUM_PORTS'(1))) != '0;
    assign gnt_stray   = (gnt_i & ~req_o) != '0;
    assign take_onehot = (take != '0) && ((take & (take - NUM_PORTS'(1))) == '0);
    assign load        = take_onehot && !gnt_multi && !gnt_stray;
    assign pop         = load ? take : '0;

    always_comb begin
        take_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (take[p]) take_idx = IW'(p);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
                if (push[p] && !pop[p])      count[p] <= count[p] + CW'(1);
                else if (!push[p] && pop[p]) count[p] <= count[p] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*DATA_W +: DATA_W];
        end
    end

    // Load wins over drain, so a word can be consumed and replaced on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            err_o     <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[take_idx][rd_ptr[take_idx]];
                out_port  <= take_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (gnt_multi || gnt_stray) err_o <= 1'b1;
        end
    end
endmodule
